// File: rtl/temporizador_semaforo.sv
// Phase timer for the traffic-light FSM: decodes the current light phase, emits one
// single-cycle advance pulse per phase, latches pedestrian requests and flags bad lights.
module temporizador_semaforo #(
    parameter int CNT_W          = 16,
    parameter int TICKS_VERMELHO = 50,
    parameter int TICKS_VERDE    = 40,
    parameter int TICKS_AMARELO  = 10,
    parameter int MIN_VERDE      = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic vermelho,
    input  logic amarelo,
    input  logic verde,
    input  logic botao_pedestre,
    output logic pulso,
    output logic pedido_pendente,
    output logic erro
);

    localparam logic [2:0] FASE_INIT     = 3'd0;
    localparam logic [2:0] FASE_VERMELHO = 3'd1;
    localparam logic [2:0] FASE_AMARELO  = 3'd2;
    localparam logic [2:0] FASE_VERDE    = 3'd3;
    localparam logic [2:0] FASE_INVALIDA = 3'd4;

    localparam logic [63:0] LIMITE_CNT = 64'd1 << CNT_W;

    if (TICKS_VERMELHO < 1 || TICKS_VERDE < 1 || TICKS_AMARELO < 1 || MIN_VERDE < 1 ||
        MIN_VERDE > TICKS_VERDE ||
        64'(TICKS_VERMELHO) >= LIMITE_CNT || 64'(TICKS_VERDE) >= LIMITE_CNT ||
        64'(TICKS_AMARELO) >= LIMITE_CNT) begin : g_param_invalido
        $error("temporizador_semaforo: invalid timing parameters");
    end

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] FIM_VM      = CNT_W'(TICKS_VERMELHO - 1);
    localparam logic [CNT_W-1:0] FIM_VD      = CNT_W'(TICKS_VERDE - 1);
    localparam logic [CNT_W-1:0] FIM_AM      = CNT_W'(TICKS_AMARELO - 1);
    localparam logic [CNT_W-1:0] FIM_MIN_VD  = CNT_W'(MIN_VERDE - 1);

    logic [2:0]       r_fase_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_feito;
    logic             r_pulso;
    logic             r_pedido;
    logic             r_erro;
    logic             r_botao_q;

    logic [2:0]       w_fase;
    logic [CNT_W-1:0] w_fim;
    logic             w_cronometrada;
    logic             w_entrada;
    logic             w_limite;
    logic             w_disparo;
    logic             w_conta;
    logic             w_subida;

    always_comb begin
        w_fase = FASE_INVALIDA;
        case ({vermelho, amarelo, verde})
            3'b100:  w_fase = FASE_VERMELHO;
            3'b010:  w_fase = FASE_AMARELO;
            3'b001:  w_fase = FASE_VERDE;
            3'b110:  w_fase = FASE_INIT;
            default: w_fase = FASE_INVALIDA;
        endcase
    end

    // INIT and INVALIDA have no duration: they never count and never pulse.
    always_comb begin
        w_fim          = '0;
        w_cronometrada = 1'b1;
        case (w_fase)
            FASE_VERMELHO: w_fim = FIM_VM;
            FASE_AMARELO:  w_fim = FIM_AM;
            FASE_VERDE:    w_fim = FIM_VD;
            default:       w_cronometrada = 1'b0;
        endcase
    end

    assign w_entrada = (w_fase != r_fase_q);
    assign w_limite  = (r_cnt == w_fim) ||
                       ((w_fase == FASE_VERDE) && r_pedido && (r_cnt >= FIM_MIN_VD));
    assign w_conta   = !w_entrada && enable && !r_feito && w_cronometrada;
    assign w_disparo = w_conta && w_limite;
    assign w_subida  = botao_pedestre && !r_botao_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fase_q  <= FASE_INIT;
            r_cnt     <= '0;
            r_feito   <= 1'b0;
            r_pulso   <= 1'b0;
            r_erro    <= 1'b0;
            r_botao_q <= 1'b0;
        end else begin
            r_fase_q  <= w_fase;
            r_erro    <= (w_fase == FASE_INVALIDA);
            r_botao_q <= botao_pedestre;
            if (w_entrada) begin
                r_cnt   <= '0;
                r_feito <= 1'b0;
                r_pulso <= 1'b0;
            end else begin
                r_pulso <= w_disparo;
                if (w_disparo) begin
                    r_feito <= 1'b1;
                end
                if (w_conta && (r_cnt != CNT_MAX)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // Serving green clears the request; a press on that same edge is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pedido <= 1'b0;
        end else if (w_disparo && (w_fase == FASE_VERDE)) begin
            r_pedido <= 1'b0;
        end else if (w_subida) begin
            r_pedido <= 1'b1;
        end
    end

    assign pulso           = r_pulso;
    assign pedido_pendente = r_pedido;
    assign erro            = r_erro;

endmodule

// File: tb/tb_temporizador_semaforo.sv
// Bench for temporizador_semaforo: behavioural phase model feeds an expected-pulse queue,
// a monitor checks pulses, erro and pedido_pendente; directed phases plus a random FSM loop.
module tb_temporizador_semaforo;

    localparam int TV   = 50;
    localparam int TG   = 40;
    localparam int TA   = 10;
    localparam int TMIN = 10;

    logic clk;
    logic rst_n;
    logic enable;
    logic vermelho;
    logic amarelo;
    logic verde;
    logic botao;
    logic pulso;
    logic pedido;
    logic erro;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fila[$];
    bit exp_erro = 1'b0;
    bit exp_ped  = 1'b0;

    temporizador_semaforo dut (
        .clk            (clk),
        .rst            (rst_n),
        .enable         (enable),
        .vermelho       (vermelho),
        .amarelo        (amarelo),
        .verde          (verde),
        .botao_pedestre (botao),
        .pulso          (pulso),
        .pedido_pendente(pedido),
        .erro           (erro)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nome, input int val, input int esp);
        total++;
        if (val != esp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nome, val, esp, cyc);
        end
    endtask

    // 0=init 1=red 2=yellow 3=green 4=illegal
    function automatic int fase_de(input logic v, input logic a, input logic g);
        case ({v, a, g})
            3'b100:  return 1;
            3'b010:  return 2;
            3'b001:  return 3;
            3'b110:  return 0;
            default: return 4;
        endcase
    endfunction

    function automatic int duracao(input int f);
        case (f)
            1:       return TV;
            2:       return TA;
            3:       return TG;
            default: return 0;
        endcase
    endfunction

    // Reference: a phase ends after `duracao` enabled cycles of unchanged lights,
    // or after TMIN enabled cycles of green once a request is pending.
    initial begin : modelo
        int  fase_ant;
        int  decorridos;
        int  f;
        bit  enviado;
        bit  pendente;
        bit  botao_ant;
        bit  dispara;
        fase_ant = 0; decorridos = 0; enviado = 0; pendente = 0; botao_ant = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                fase_ant = 0; decorridos = 0; enviado = 0; pendente = 0; botao_ant = 0;
                exp_erro = 0; exp_ped = 0;
                fila.delete();
            end else begin
                cyc++;
                f = fase_de(vermelho, amarelo, verde);
                dispara = 0;
                if (f != fase_ant) begin
                    decorridos = 0;
                    enviado    = 0;
                end else if (enable && !enviado && duracao(f) > 0) begin
                    decorridos++;
                    if (decorridos >= duracao(f) || (f == 3 && pendente && decorridos >= TMIN))
                        dispara = 1;
                end
                if (dispara) begin
                    enviado = 1;
                    fila.push_back(cyc);
                end
                if (dispara && f == 3) pendente = 0;
                else if (botao && !botao_ant) pendente = 1;
                botao_ant = botao;
                fase_ant  = f;
                exp_erro  = (f == 4);
                exp_ped   = pendente;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            while (fila.size() > 0 && fila[0] < cyc) begin
                chk("pulso_ausente", 0, fila.pop_front());
            end
            if (pulso === 1'b1) begin
                if (fila.size() == 0) chk("pulso_inesperado", cyc, -1);
                else                  chk("pulso_ciclo", cyc, fila.pop_front());
            end
            chk("erro", int'(erro), int'(exp_erro));
            chk("pedido", int'(pedido), int'(exp_ped));
        end
    end

    task automatic ciclo(input logic [2:0] luz, input logic en, input logic bt);
        {vermelho, amarelo, verde} = luz;
        enable = en;
        botao  = bt;
        @(posedge clk);
        #2;
    endtask

    // Holds one light combination for n cycles; i=1 is the entry edge.
    task automatic fase(input logic [2:0] luz, input int n, input int bt_em,
                        input int off_ini, input int off_n, output int idx, output int npul);
        idx  = 0;
        npul = 0;
        for (int i = 1; i <= n; i++) begin
            ciclo(luz, !(i >= off_ini && i < off_ini + off_n), (i == bt_em));
            if (pulso === 1'b1) begin
                npul++;
                if (idx == 0) idx = i;
            end
        end
    endtask

    function automatic logic [2:0] proxima(input logic [2:0] luz);
        case (luz)
            3'b100:  return 3'b001;
            3'b001:  return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    initial begin : estimulo
        int idx;
        int np;
        logic [2:0] luz;
        rst_n = 1'b0;
        {vermelho, amarelo, verde} = 3'b110;
        enable = 1'b0;
        botao  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_pulso", int'(pulso), 0);
        chk("reset_pedido", int'(pedido), 0);
        chk("reset_erro", int'(erro), 0);
        rst_n = 1'b1;

        fase(3'b110, 3, 0, 0, 0, idx, np);
        chk("init_sem_pulso", np, 0);
        fase(3'b100, 70, 0, 0, 0, idx, np);
        chk("vermelho_latencia", idx, TV + 1);
        chk("vermelho_pulso_unico", np, 1);

        fase(3'b001, 45, 0, 0, 0, idx, np);
        chk("verde_normal", idx, TG + 1);
        fase(3'b010, 12, 0, 0, 0, idx, np);
        chk("amarelo_normal", idx, TA + 1);
        fase(3'b100, 55, 3, 0, 0, idx, np);
        chk("vermelho_com_pedido", idx, TV + 1);
        chk("pedido_latched", int'(pedido), 1);
        fase(3'b001, 15, 0, 0, 0, idx, np);
        chk("verde_minimo", idx, TMIN + 1);
        chk("verde_minimo_unico", np, 1);
        chk("pedido_servido", int'(pedido), 0);
        fase(3'b010, 12, 0, 0, 0, idx, np);
        fase(3'b100, 55, 0, 0, 0, idx, np);
        fase(3'b001, 30, 25, 0, 0, idx, np);
        chk("verde_pedido_tardio", idx, 26);
        chk("pedido_tardio_limpo", int'(pedido), 0);

        fase(3'b010, 25, 0, 4, 7, idx, np);
        chk("amarelo_enable_pausa", idx, TA + 1 + 7);

        fase(3'b011, 5, 0, 0, 0, idx, np);
        chk("invalida_011_sem_pulso", np, 0);
        chk("invalida_011_erro", int'(erro), 1);
        fase(3'b000, 5, 0, 0, 0, idx, np);
        chk("invalida_000_sem_pulso", np, 0);
        chk("invalida_000_erro", int'(erro), 1);
        fase(3'b100, 55, 0, 0, 0, idx, np);
        chk("vermelho_apos_invalida", idx, TV + 1);
        chk("erro_limpo", int'(erro), 0);

        fase(3'b001, 5, 2, 0, 0, idx, np);
        chk("pedido_antes_reset", int'(pedido), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_async_pulso", int'(pulso), 0);
        chk("reset_async_pedido", int'(pedido), 0);
        chk("reset_async_erro", int'(erro), 0);
        ciclo(3'b001, 1'b1, 1'b0);
        ciclo(3'b110, 1'b1, 1'b0);
        rst_n = 1'b1;
        fase(3'b110, 20, 0, 0, 0, idx, np);
        chk("init_pos_reset_sem_pulso", np, 0);

        luz = 3'b100;
        for (int i = 0; i < 1500; i++) begin
            ciclo(luz, ($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0));
            if (pulso === 1'b1) luz = proxima(luz);
        end
        ciclo(luz, 1'b0, 1'b0);
        ciclo(luz, 1'b0, 1'b0);
        chk("fila_vazia", fila.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
